// File: rtl/seven_seg_mux.sv
// Time-multiplexed hex driver for NUM_DIGITS seven-segment digits on one segment bus.
// New digit values are loaded only at frame boundaries, so a frame never shows mixed data.
module seven_seg_mux #(
    parameter int unsigned NUM_DIGITS     = 2,
    parameter int unsigned REFRESH_DIV    = 24000,
    parameter int unsigned BLANK_CYCLES   = 240,
    parameter bit          SEG_ACTIVE_LOW = 1'b1,
    parameter bit          DIG_ACTIVE_LOW = 1'b1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] digits_in,
    input  logic                    blank_zero,
    output logic [6:0]              seven_seg,
    output logic [NUM_DIGITS-1:0]   digit_en,
    output logic                    load_ack,
    output logic                    frame_tick
);

    localparam int unsigned CntW  = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int unsigned SlotW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int unsigned DataW = 4 * NUM_DIGITS;

    localparam logic [CntW-1:0]       CntMax   = CntW'(REFRESH_DIV - 1);
    localparam logic [CntW-1:0]       BlankEnd = CntW'(BLANK_CYCLES);
    localparam logic [SlotW-1:0]      SlotMax  = SlotW'(NUM_DIGITS - 1);
    localparam logic [6:0]            SegOff   = {7{SEG_ACTIVE_LOW}};
    localparam logic [NUM_DIGITS-1:0] DigOff   = {NUM_DIGITS{DIG_ACTIVE_LOW}};

    logic [CntW-1:0]       cnt_q, cnt_d;
    logic [SlotW-1:0]      slot_q, slot_d;
    logic [DataW-1:0]      display_q, display_d;
    logic [DataW-1:0]      pending_q, pending_d;
    logic                  pending_valid_q, pending_valid_d;
    logic [6:0]            seg_q, seg_d;
    logic [NUM_DIGITS-1:0] dig_q, dig_d;
    logic                  ack_q, ack_d;
    logic                  tick_q, tick_d;

    logic                  slot_end;
    logic                  boundary;
    logic [3:0]            cur_nib;
    logic                  cur_blank;
    logic [NUM_DIGITS:0]   zero_from;
    logic [NUM_DIGITS-1:0] dig_onehot;
    logic [6:0]            seg_on;

    // Active-high gfedcba pattern for one hex nibble.
    function automatic logic [6:0] hex_decode(input logic [3:0] nib);
        logic [6:0] pat;
        case (nib)
            4'h0:    pat = 7'b0111111;
            4'h1:    pat = 7'b0000110;
            4'h2:    pat = 7'b1011011;
            4'h3:    pat = 7'b1001111;
            4'h4:    pat = 7'b1100110;
            4'h5:    pat = 7'b1101101;
            4'h6:    pat = 7'b1111101;
            4'h7:    pat = 7'b0000111;
            4'h8:    pat = 7'b1111111;
            4'h9:    pat = 7'b1101111;
            4'hA:    pat = 7'b1110111;
            4'hB:    pat = 7'b1111100;
            4'hC:    pat = 7'b0111001;
            4'hD:    pat = 7'b1011110;
            4'hE:    pat = 7'b1111001;
            default: pat = 7'b1110001;
        endcase
        return pat;
    endfunction

    always_comb begin
        slot_end = (cnt_q == CntMax);
        boundary = slot_end && (slot_q == SlotMax);
        cnt_d    = slot_end ? '0 : cnt_q + 1'b1;
        slot_d   = slot_q;
        if (slot_end) begin
            slot_d = (slot_q == SlotMax) ? '0 : slot_q + 1'b1;
        end
    end

    // A load in the boundary cycle itself bypasses pending and lands directly.
    always_comb begin
        display_d       = display_q;
        pending_d       = pending_q;
        pending_valid_d = pending_valid_q;
        if (boundary && load) begin
            display_d       = digits_in;
            pending_valid_d = 1'b0;
        end else if (boundary && pending_valid_q) begin
            display_d       = pending_q;
            pending_valid_d = 1'b0;
        end else if (load) begin
            pending_d       = digits_in;
            pending_valid_d = 1'b1;
        end
        ack_d  = boundary && (load || pending_valid_q);
        tick_d = boundary;
    end

    // zero_from[k] is set when nibble k and every higher nibble are zero.
    always_comb begin
        zero_from[NUM_DIGITS] = 1'b1;
        for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
            zero_from[k] = zero_from[k+1] && (display_q[4*k +: 4] == 4'h0);
        end
    end

    always_comb begin
        cur_nib    = 4'h0;
        cur_blank  = 1'b0;
        dig_onehot = '0;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (slot_q == SlotW'(k)) begin
                cur_nib   = display_q[4*k +: 4];
                cur_blank = blank_zero && (k != 0) && zero_from[k];
                if (cnt_q >= BlankEnd) begin
                    dig_onehot[k] = 1'b1;
                end
            end
        end
        seg_on = cur_blank ? 7'b0000000 : hex_decode(cur_nib);
        seg_d  = SEG_ACTIVE_LOW ? ~seg_on : seg_on;
        dig_d  = DIG_ACTIVE_LOW ? ~dig_onehot : dig_onehot;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q           <= '0;
            slot_q          <= '0;
            display_q       <= '0;
            pending_q       <= '0;
            pending_valid_q <= 1'b0;
            seg_q           <= SegOff;
            dig_q           <= DigOff;
            ack_q           <= 1'b0;
            tick_q          <= 1'b0;
        end else begin
            cnt_q           <= cnt_d;
            slot_q          <= slot_d;
            display_q       <= display_d;
            pending_q       <= pending_d;
            pending_valid_q <= pending_valid_d;
            seg_q           <= seg_d;
            dig_q           <= dig_d;
            ack_q           <= ack_d;
            tick_q          <= tick_d;
        end
    end

    assign seven_seg  = seg_q;
    assign digit_en   = dig_q;
    assign load_ack   = ack_q;
    assign frame_tick = tick_q;

endmodule
